// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl
// Upstream driver for the 8x8 matrix display stage. Generates the display
// column-scan strobe (CE) and the 4-bit symbol code (SEQ). The host fills
// a 16-entry message buffer; playback steps through it, holding each symbol
// for HOLD_FRAMES display frames, either once or looping.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   wr_en      message buffer write strobe
//   wr_addr    buffer entry index
//   wr_data    symbol code written to the buffer
//   msg_len    message length 1..16 (values above 16 clamp), sampled on start
//   loop       1 = wrap to entry 0 after the last entry, sampled on start
//   start      pulse: begin / restart playback at entry 0
//   stop       pulse: abort playback (wins over start)
//   CE         one-clk pulse every PRESCALE clks
//   SEQ        current symbol code
//   busy       high while playing
//   frame_end  high with the CE pulse that closes a display frame
//   done       one-clk pulse when one-shot playback completes
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no playback; SEQ holds its last value
// S_RUN  | stepping through the buffer, one symbol per HOLD_FRAMES frames

module matrix_seq_ctrl #(
    parameter int PRESCALE    = 50000,
    parameter int HOLD_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [4:0] msg_len,
    input  logic       loop,
    input  logic       start,
    input  logic       stop,
    output logic       CE,
    output logic [3:0] SEQ,
    output logic       busy,
    output logic       frame_end,
    output logic       done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int FW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc;
    logic [2:0]      phase;
    logic            tick;
    logic [FW-1:0]   frame_cnt;
    logic [3:0]      index;
    logic [4:0]      len_q;
    logic            loop_q;
    logic [3:0]      mem [16];

    logic            start_ok;
    logic [4:0]      len_eff;
    logic            hold_end;
    logic            last;
    logic            finish;

    // Prescaler and column phase run in every state so the phase stays
    // locked to the display's own column counter.
    assign tick = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            phase     <= 3'd0;
            CE        <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            CE        <= tick;
            // phase advances when the display consumes CE, so during a CE
            // pulse it still names the column being closed.
            frame_end <= tick && (phase == 3'd7);
            if (CE)
                phase <= phase + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign start_ok = start && !stop && (msg_len != 5'd0);
    assign len_eff  = (msg_len > 5'd16) ? 5'd16 : msg_len;
    assign hold_end = frame_end && (frame_cnt == FW'(HOLD_FRAMES - 1));
    assign last     = ({1'b0, index} == (len_q - 5'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start_ok) state_n = S_RUN;
            S_RUN: begin
                if (stop)
                    state_n = S_IDLE;
                else if (start_ok)
                    state_n = S_RUN;
                else if (hold_end && last && !loop_q)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_RUN);
        finish = (state == S_RUN) && !stop && !start_ok && hold_end && last && !loop_q;
    end

    // SEQ changes on the same edge that consumes frame_end; the display
    // therefore shows each new symbol one frame later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            index     <= 4'd0;
            len_q     <= 5'd0;
            loop_q    <= 1'b0;
            SEQ       <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (start_ok) begin
                frame_cnt <= '0;
                index     <= 4'd0;
                len_q     <= len_eff;
                loop_q    <= loop;
                SEQ       <= mem[0];
            end else if ((state == S_RUN) && !stop && frame_end) begin
                if (hold_end) begin
                    frame_cnt <= '0;
                    if (!last) begin
                        index <= index + 4'd1;
                        SEQ   <= mem[index + 4'd1];
                    end else if (loop_q) begin
                        index <= 4'd0;
                        SEQ   <= mem[0];
                    end
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule
